// File: rtl/rgb_to_gray_stream.sv
// rgb_to_gray_stream: streaming RGB -> grayscale converter for the image filter path.
// Each beat carries NUM_PIXELS RGB pixels. All pixels are converted in parallel
// through a two-stage pipeline (S1 arithmetic, S2 output register) with valid/ready
// handshakes and full backpressure on both sides.
// Runtime mode (sampled with the beat): 0 = mean (R+G+B)/3, 1 = integer BT.601 luma.
// Optional feature macro GRAY_THRESHOLD_EN adds the ports threshold and bin_en.
// They apply per-beat binarisation in S2, so the pipeline latency does not change.
module rgb_to_gray_stream #(
  parameter int BIT_PER_PIXEL = 8,
  parameter int NUM_PIXELS    = 9
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_PIXELS*3*BIT_PER_PIXEL-1:0] in_rgb,
  input  logic                                  in_mode,
`ifdef GRAY_THRESHOLD_EN
  input  logic [BIT_PER_PIXEL-1:0]              threshold,
  input  logic                                  bin_en,
`endif
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_PIXELS*BIT_PER_PIXEL-1:0]   out_gray,
  output logic [15:0]                           beat_cnt
);

  localparam int BPP = BIT_PER_PIXEL;
  // One S1 slot per pixel. It is wide enough for the luma accumulator.
  // The mean sum only occupies the low BPP+2 bits of the slot.
  localparam int AW  = BPP + 8;
  localparam logic [BPP+1:0] THREE = (BPP+2)'(3);

  logic                         s1_valid_reg;
  logic                         s1_mode_reg;
  logic [NUM_PIXELS*AW-1:0]     s1_val_reg;
  logic [NUM_PIXELS*AW-1:0]     s1_val_next;
  logic                         s2_valid_reg;
  logic [NUM_PIXELS*BPP-1:0]    out_gray_reg;
  logic [NUM_PIXELS*BPP-1:0]    out_gray_next;
  logic [15:0]                  beat_cnt_reg;
  logic                         s1_adv;
  logic                         s2_adv;
`ifdef GRAY_THRESHOLD_EN
  logic [BPP-1:0]               s1_thr_reg;
  logic                         s1_bin_reg;
`endif

  // Advance conditions. in_ready is combinational from out_ready.
  // This lets a full pipeline accept a new beat in the same cycle it emits one.
  always_comb begin
    s2_adv   = !s2_valid_reg || out_ready;
    s1_adv   = !s1_valid_reg || s2_adv;
    in_ready = s1_adv;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIXELS; gi++) begin : g_px
      logic [AW-1:0]  r_w;
      logic [AW-1:0]  g_w;
      logic [AW-1:0]  b_w;
      logic [BPP-1:0] mean_gray;
      logic [BPP-1:0] luma_gray;
      logic [BPP-1:0] plain_gray;

      assign r_w = AW'(in_rgb[(3*gi+0)*BPP +: BPP]);
      assign g_w = AW'(in_rgb[(3*gi+1)*BPP +: BPP]);
      assign b_w = AW'(in_rgb[(3*gi+2)*BPP +: BPP]);

      // S1: the luma weights sum to 256, so the accumulator never exceeds BPP+8 bits.
      assign s1_val_next[gi*AW +: AW] = in_mode
          ? (r_w * AW'(77) + g_w * AW'(150) + b_w * AW'(29))
          : (r_w + g_w + b_w);

      // S2: both reductions land exactly in BPP bits, so no saturation is needed.
      assign mean_gray  = BPP'(s1_val_reg[gi*AW +: BPP+2] / THREE);
      assign luma_gray  = s1_val_reg[gi*AW+8 +: BPP];
      assign plain_gray = s1_mode_reg ? luma_gray : mean_gray;

`ifdef GRAY_THRESHOLD_EN
      assign out_gray_next[gi*BPP +: BPP] = s1_bin_reg
          ? {BPP{(plain_gray >= s1_thr_reg)}}
          : plain_gray;
`else
      assign out_gray_next[gi*BPP +: BPP] = plain_gray;
`endif
    end
  endgenerate

  // S1 register: load a new beat whenever S1 can advance.
  // The mode and threshold settings travel with the beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_mode_reg  <= 1'b0;
      s1_val_reg   <= '0;
`ifdef GRAY_THRESHOLD_EN
      s1_thr_reg   <= '0;
      s1_bin_reg   <= 1'b0;
`endif
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_mode_reg <= in_mode;
        s1_val_reg  <= s1_val_next;
`ifdef GRAY_THRESHOLD_EN
        s1_thr_reg  <= threshold;
        s1_bin_reg  <= bin_en;
`endif
      end
    end
  end

  // S2 output register. It holds its contents while the downstream side stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      out_gray_reg <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_gray_reg <= out_gray_next;
      end
    end
  end

  // Count accepted output beats. The counter wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_reg <= '0;
    end else if (s2_valid_reg && out_ready) begin
      beat_cnt_reg <= beat_cnt_reg + 16'd1;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_gray  = out_gray_reg;
  assign beat_cnt  = beat_cnt_reg;

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// tb_rgb_to_gray_stream: self-checking bench for rgb_to_gray_stream.
// Expected beats come from a plain-arithmetic model and are queued at acceptance.
// Each queued beat is compared in order when the DUT hands an output beat downstream.
module tb_rgb_to_gray_stream;
  localparam int BPP = 8;
  localparam int NP  = 9;
  localparam int RW  = NP*3*BPP;
  localparam int GW  = NP*BPP;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] in_rgb = '0;
  logic          in_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [GW-1:0] out_gray;
  logic [15:0]   beat_cnt;
`ifdef GRAY_THRESHOLD_EN
  logic [BPP-1:0] threshold = '0;
  logic           bin_en = 1'b0;
`endif

  always #5 clk = ~clk;

  rgb_to_gray_stream #(.BIT_PER_PIXEL(BPP), .NUM_PIXELS(NP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rgb    (in_rgb),
    .in_mode   (in_mode),
`ifdef GRAY_THRESHOLD_EN
    .threshold (threshold),
    .bin_en    (bin_en),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .beat_cnt  (beat_cnt)
  );

  int            errors = 0;
  int            checks = 0;
  int            pops = 0;
  int            accepts = 0;
  logic [GW-1:0] exp_q[$];
  bit            stall_pending = 1'b0;
  logic [GW-1:0] held = '0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: gray value of one pixel, straight from the arithmetic definition.
  function automatic logic [BPP-1:0] gray_px(int r, int g, int b, bit mode, int thr, bit bin);
    int v;
    if (mode) v = (77*r + 150*g + 29*b) / 256;
    else      v = (r + g + b) / 3;
    if (bin)  v = (v >= thr) ? 255 : 0;
    return BPP'(v);
  endfunction

  function automatic logic [GW-1:0] gray_vec(logic [RW-1:0] rgb, bit mode, int thr, bit bin);
    logic [GW-1:0] o;
    o = '0;
    for (int i = 0; i < NP; i++) begin
      o[i*BPP +: BPP] = gray_px(int'(rgb[(3*i)*BPP +: BPP]), int'(rgb[(3*i+1)*BPP +: BPP]),
                                int'(rgb[(3*i+2)*BPP +: BPP]), mode, thr, bin);
    end
    return o;
  endfunction

  function automatic logic [RW-1:0] rand_rgb();
    logic [RW-1:0] v;
    for (int i = 0; i < NP*3; i++) begin
      case ($urandom_range(0, 7))
        0:       v[i*BPP +: BPP] = '0;
        1:       v[i*BPP +: BPP] = '1;
        default: v[i*BPP +: BPP] = BPP'($urandom);
      endcase
    end
    return v;
  endfunction

  // Drive one cycle of inputs and observe the outputs 1ns later.
  // The bench then advances to 1ns past the next rising edge.
  task automatic cycle(bit iv, logic [RW-1:0] rgb, bit mode, int thr, bit bin, bit ordy);
    in_valid  = iv;
    in_rgb    = rgb;
    in_mode   = mode;
    out_ready = ordy;
`ifdef GRAY_THRESHOLD_EN
    threshold = BPP'(thr);
    bin_en    = bin;
`endif
    #1;
    if (stall_pending) begin
      check("stall_valid", 128'(out_valid), 128'(1));
      check("stall_hold", 128'(out_gray), 128'(held));
    end
    stall_pending = out_valid && !out_ready;
    held = out_gray;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_beat", 128'(out_valid), 128'(0));
      else                   check("beat_data", 128'(out_gray), 128'(exp_q.pop_front()));
      pops++;
      $display("beat %0d out_gray=%h", pops, out_gray);
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(gray_vec(rgb, mode, thr, bin));
      accepts++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    stall_pending = 1'b0;
    pops = 0;
    accepts = 0;
  endtask

  task automatic drain(string tag);
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) cycle(1'b0, '0, 1'b0, 0, 1'b0, 1'b1);
    check(tag, 128'(exp_q.size()), 128'(0));
  endtask

  // Send one beat into an empty pipeline and confirm it appears two cycles later.
  task automatic single_beat(string tag, logic [RW-1:0] rgb, bit mode, int thr, bit bin,
                             logic [GW-1:0] exp_const);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    cycle(1'b1, rgb, mode, thr, bin, 1'b1);
    check({tag, "_lat1"}, 128'(out_valid), 128'(0));
    cycle(1'b0, rgb, mode, thr, bin, 1'b1);
    check({tag, "_lat2"}, 128'(out_valid), 128'(1));
    check({tag, "_gray"}, 128'(out_gray), 128'(exp_const));
    cycle(1'b0, rgb, mode, thr, bin, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [RW-1:0] rgb;
    logic [GW-1:0] expv;
    int            k;
    bit            bin_r;
    int            thr_r;

    // Reset held three cycles.
    do_reset(3);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_beat_cnt", 128'(beat_cnt), 128'(0));
    check("rst_out_gray", 128'(out_gray), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // Mean mode with every pixel at (30,60,90), which should give 60 everywhere.
    rgb = '0;
    expv = '0;
    for (int i = 0; i < NP; i++) begin
      rgb[(3*i)*BPP +: BPP]   = 8'd30;
      rgb[(3*i+1)*BPP +: BPP] = 8'd60;
      rgb[(3*i+2)*BPP +: BPP] = 8'd90;
      expv[i*BPP +: BPP]      = 8'd60;
    end
    single_beat("t2_mean", rgb, 1'b0, 0, 1'b0, expv);

    // Luma mode with pure primary colours and white.
    rgb = '0;
    rgb[0*BPP +: BPP]  = 8'd255;
    rgb[4*BPP +: BPP]  = 8'd255;
    rgb[8*BPP +: BPP]  = 8'd255;
    rgb[9*BPP +: 24]   = 24'hFFFFFF;
    expv = '0;
    expv[0*BPP +: BPP] = 8'd76;
    expv[1*BPP +: BPP] = 8'd149;
    expv[2*BPP +: BPP] = 8'd28;
    expv[3*BPP +: BPP] = 8'd255;
    single_beat("t3_luma", rgb, 1'b1, 0, 1'b0, expv);

    // Mean truncation corner: (255,255,254) gives 254.
    rgb = '0;
    rgb[0 +: 24] = {8'd254, 8'd255, 8'd255};
    expv = '0;
    expv[0 +: BPP] = 8'd254;
    single_beat("mean_trunc", rgb, 1'b0, 0, 1'b0, expv);

`ifdef GRAY_THRESHOLD_EN
    // Binarisation at threshold 128: a mean of 128 maps to 255, a mean of 100 maps to 0.
    rgb = '0;
    rgb[0 +: 24]  = {8'd129, 8'd128, 8'd127};
    rgb[24 +: 24] = {8'd100, 8'd100, 8'd100};
    expv = '0;
    expv[0 +: BPP] = 8'd255;
    single_beat("t6_bin", rgb, 1'b0, 128, 1'b1, expv);
`endif

    // 20 back-to-back beats with out_ready following the repeating pattern 1,0,0,1.
    do_reset(2);
    k = 0;
    while (pops < 20 && k < 300) begin
      cycle(accepts < 20, rand_rgb(), 1'($urandom), 0, 1'b0, (k % 4 == 0) || (k % 4 == 3));
      k++;
    end
    check("t4_pops", 128'(pops), 128'(20));
    check("t4_beat_cnt", 128'(beat_cnt), 128'(20));
    check("t4_queue", 128'(exp_q.size()), 128'(0));

    // Reset while two beats are in flight: neither beat may emerge afterwards.
    do_reset(1);
    cycle(1'b1, rand_rgb(), 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, rand_rgb(), 1'b1, 0, 1'b0, 1'b0);
    check("t5_inflight", 128'(out_valid), 128'(1));
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 0, 1'b0, 1'b1);
      check("t5_flushed", 128'(out_valid), 128'(0));
    end
    check("t5_beat_cnt", 128'(beat_cnt), 128'(0));
    rgb = rand_rgb();
    single_beat("t5_after", rgb, 1'b1, 0, 1'b0, gray_vec(rgb, 1'b1, 0, 1'b0));

    // Randomized traffic with random stalls on both sides.
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      bin_r = 1'b0;
      thr_r = 0;
`ifdef GRAY_THRESHOLD_EN
      bin_r = 1'($urandom);
      thr_r = int'($urandom_range(0, 255));
`endif
      cycle($urandom_range(0, 3) != 0, rand_rgb(), 1'($urandom), thr_r, bin_r,
            $urandom_range(0, 2) != 0);
    end
    drain("rand_drain");
    check("rand_beat_cnt", 128'(beat_cnt), 128'(pops[15:0]));
    check("rand_count", 128'(pops), 128'(accepts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
